pc_stack_sequencer: RTL and testbench

//  Program-counter sequencer with hardware return-address stack for the 4-bit-opcode CPU.

---
 rtl/pc_stack_sequencer.sv | 103 ++++++++++
 tb/tb_pc_stack_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pc_stack_sequencer.sv
// Program-counter sequencer with a hardware return-address stack, halt and stack-fault handling.
// Optional macro PC_TRAP_EN: stack overflow/underflow traps to TRAP_VEC and parks in FAULT.
module pc_stack_sequencer #(
    parameter int              PC_W     = 8,
    parameter int              DEPTH    = 8,
    parameter logic [PC_W-1:0] RST_VEC  = '0,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'('hF0)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  jump,
    input  logic                  ret,
    input  logic                  push,
    input  logic [PC_W-1:0]       target,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [PC_W-1:0]       pc,
    output logic [$clog2(DEPTH):0] sp,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  fault,
    output logic                  halted
);
    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;

    typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;
    state_t state;

    logic [PC_W-1:0] stack_mem [DEPTH];
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] top;
    logic            advance;
    logic            overflow;
    logic            underflow;
    logic            push_ok;

    assign stack_full  = (sp == SP_W'(DEPTH));
    assign stack_empty = (sp == '0);
    assign halted      = (state != S_RUN);

    assign pc_inc    = pc + PC_W'(1);
    // Read from the registered sp so a ret right after a call sees the fresh entry.
    assign top       = stack_mem[AW'(sp - SP_W'(1))];
    assign advance   = en && (state == S_RUN) && !halt_req;
    assign underflow = advance && ret && stack_empty;
    assign overflow  = advance && !ret && push && stack_full;
    assign push_ok   = advance && !ret && push && !stack_full;

`ifndef PC_TRAP_EN
    // The trap vector has no use without the trap option.
    logic unused_trap;
    assign unused_trap = ^TRAP_VEC;
`endif

    always_ff @(posedge clk) begin
        if (push_ok)
            stack_mem[AW'(sp)] <= pc_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RST_VEC;
            sp    <= '0;
            fault <= 1'b0;
            state <= S_RUN;
        end else if (en) begin
            case (state)
                S_RUN: begin
                    if (halt_req) begin
                        state <= S_HALT;
                    end else if (overflow || underflow) begin
                        fault <= 1'b1;
`ifdef PC_TRAP_EN
                        state <= S_FAULT;
                        pc    <= TRAP_VEC;
`else
                        // Stack action is dropped; the jump part of a call still goes ahead.
                        if (underflow)
                            pc <= pc_inc;
                        else if (jump)
                            pc <= target;
                        else
                            pc <= pc_inc;
`endif
                    end else if (ret) begin
                        pc <= top;
                        sp <= sp - SP_W'(1);
                    end else begin
                        pc <= jump ? target : pc_inc;
                        if (push)
                            sp <= sp + SP_W'(1);
                    end
                end
                default: begin
                    if (resume)
                        state <= S_RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed bench for pc_stack_sequencer: expected state queued per step, popped after the edge.
// Covers reset, nested calls, wrap, overflow/underflow (both PC_TRAP_EN builds), halt and enable.
module tb_pc_stack_sequencer;
    logic       clk = 1'b0;
    logic       rst, en, jump, ret, push, halt_req, resume;
    logic [7:0] target;
    logic [7:0] pc;
    logic [3:0] sp;
    logic       stack_full, stack_empty, fault, halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] pc;
        logic [3:0] sp;
        logic       fault;
        logic       halted;
        string      tag;
    } exp_t;
    exp_t sb[$];

    pc_stack_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .jump(jump), .ret(ret), .push(push),
        .target(target), .halt_req(halt_req), .resume(resume),
        .pc(pc), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
        .fault(fault), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input exp_t e);
        chk({e.tag, ".pc"},     32'(pc),          32'(e.pc));
        chk({e.tag, ".sp"},     32'(sp),          32'(e.sp));
        chk({e.tag, ".fault"},  32'(fault),       32'(e.fault));
        chk({e.tag, ".halted"}, 32'(halted),      32'(e.halted));
        chk({e.tag, ".full"},   32'(stack_full),  32'(e.sp == 4'd8));
        chk({e.tag, ".empty"},  32'(stack_empty), 32'(e.sp == 4'd0));
    endtask

    // Drive one cycle of strobes, queue the expected result, check it just after the edge.
    task automatic step(input string tag, input logic e, input logic j, input logic r,
                        input logic p, input logic [7:0] tgt, input logic h, input logic rs,
                        input logic [7:0] epc, input logic [3:0] esp, input logic ef,
                        input logic eh);
        exp_t x;
        en = e; jump = j; ret = r; push = p; target = tgt; halt_req = h; resume = rs;
        x.pc = epc; x.sp = esp; x.fault = ef; x.halted = eh; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".queue"}, 32'(0), 32'(1));
        end else begin
            x = sb.pop_front();
            chk_state(x);
        end
    endtask

    task automatic pulse_reset(input string tag);
        exp_t x;
        en = 1'b0; jump = 1'b0; ret = 1'b0; push = 1'b0; halt_req = 1'b0; resume = 1'b0;
        rst = 1'b1;
        #1;
        x.pc = 8'h00; x.sp = 4'd0; x.fault = 1'b0; x.halted = 1'b0; x.tag = tag;
        chk_state(x);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; jump = 1'b0; ret = 1'b0; push = 1'b0;
        target = 8'h00; halt_req = 1'b0; resume = 1'b0;
        #12;
        pulse_reset("reset0");
        @(negedge clk);

        // T1: build pc=0x23, sp=3, then asynchronous reset between edges
        step("t1_push1", 1, 0, 0, 1, 8'h00, 0, 0, 8'h01, 4'd1, 0, 0);
        step("t1_push2", 1, 0, 0, 1, 8'h00, 0, 0, 8'h02, 4'd2, 0, 0);
        step("t1_push3", 1, 0, 0, 1, 8'h00, 0, 0, 8'h03, 4'd3, 0, 0);
        step("t1_jump",  1, 1, 0, 0, 8'h23, 0, 0, 8'h23, 4'd3, 0, 0);
        pulse_reset("t1_rst");

        // T2: nested calls and returns
        step("t2_jmp",   1, 1, 0, 0, 8'h10, 0, 0, 8'h10, 4'd0, 0, 0);
        step("t2_call1", 1, 1, 0, 1, 8'h40, 0, 0, 8'h40, 4'd1, 0, 0);
        step("t2_call2", 1, 1, 0, 1, 8'h80, 0, 0, 8'h80, 4'd2, 0, 0);
        step("t2_ret1",  1, 0, 1, 0, 8'h00, 0, 0, 8'h41, 4'd1, 0, 0);
        step("t2_ret2",  1, 1, 1, 0, 8'h77, 0, 0, 8'h11, 4'd0, 0, 0);

        // T3: pc and pushed return address wrap
        step("t3_jff",   1, 1, 0, 0, 8'hFF, 0, 0, 8'hFF, 4'd0, 0, 0);
        step("t3_wrap",  1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 4'd0, 0, 0);
        step("t3_jff2",  1, 1, 0, 0, 8'hFF, 0, 0, 8'hFF, 4'd0, 0, 0);
        step("t3_call",  1, 1, 0, 1, 8'h20, 0, 0, 8'h20, 4'd1, 0, 0);
        step("t3_ret",   1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 4'd0, 0, 0);

        // T6: halt, enable gating, resume, ret+push
        step("t6_j12",   1, 1, 0, 0, 8'h12, 0, 0, 8'h12, 4'd0, 0, 0);
        step("t6_halt",  1, 1, 0, 0, 8'h55, 1, 0, 8'h12, 4'd0, 0, 1);
        step("t6_hold",  1, 1, 0, 1, 8'h66, 0, 0, 8'h12, 4'd0, 0, 1);
        step("t6_en0",   0, 0, 0, 0, 8'h00, 0, 1, 8'h12, 4'd0, 0, 1);
        step("t6_resume",1, 0, 0, 0, 8'h00, 0, 1, 8'h12, 4'd0, 0, 0);
        step("t6_plain", 1, 0, 0, 0, 8'h00, 0, 0, 8'h13, 4'd0, 0, 0);
        step("t6_en0cl", 0, 1, 0, 1, 8'h30, 0, 0, 8'h13, 4'd0, 0, 0);
        step("t6_call",  1, 1, 0, 1, 8'h30, 0, 0, 8'h30, 4'd1, 0, 0);
        step("t6_retpsh",1, 0, 1, 1, 8'h00, 0, 0, 8'h14, 4'd0, 0, 0);

        // T5: underflow
        step("t5_j05",   1, 1, 0, 0, 8'h05, 0, 0, 8'h05, 4'd0, 0, 0);
`ifdef PC_TRAP_EN
        step("t5_unf",   1, 0, 1, 0, 8'h00, 0, 0, 8'hF0, 4'd0, 1, 1);
        step("t5_ignore",1, 1, 0, 1, 8'h44, 0, 0, 8'hF0, 4'd0, 1, 1);
        step("t5_resume",1, 0, 0, 0, 8'h00, 0, 1, 8'hF0, 4'd0, 1, 0);
        step("t5_sticky",1, 0, 0, 0, 8'h00, 0, 0, 8'hF1, 4'd0, 1, 0);
`else
        step("t5_unf",   1, 0, 1, 0, 8'h00, 0, 0, 8'h06, 4'd0, 1, 0);
        step("t5_sticky",1, 0, 0, 0, 8'h00, 0, 0, 8'h07, 4'd0, 1, 0);
`endif
        pulse_reset("t5_rst");

        // T4: fill the stack, then overflow on the ninth call
        step("t4_j30",   1, 1, 0, 0, 8'h30, 0, 0, 8'h30, 4'd0, 0, 0);
        for (int i = 1; i <= 8; i++)
            step($sformatf("t4_call%0d", i), 1, 1, 0, 1, 8'h30, 0, 0, 8'h30, 4'(i), 0, 0);
`ifdef PC_TRAP_EN
        step("t4_ovf",   1, 1, 0, 1, 8'h50, 0, 0, 8'hF0, 4'd8, 1, 1);
        step("t4_resume",1, 0, 0, 0, 8'h00, 0, 1, 8'hF0, 4'd8, 1, 0);
        step("t4_adv",   1, 0, 0, 0, 8'h00, 0, 0, 8'hF1, 4'd8, 1, 0);
`else
        step("t4_ovf",   1, 1, 0, 1, 8'h50, 0, 0, 8'h50, 4'd8, 1, 0);
`endif
        for (int i = 7; i >= 0; i--)
            step($sformatf("t4_ret%0d", i), 1, 0, 1, 0, 8'h00, 0, 0, 8'h31, 4'(i), 1, 0);

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
